// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types
// Description : Types shared by the fetch predictor and the branch resolver.
//               This includes the training update record and the resolver
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

   // One predictor training record: the branch PC, its actual target, and
   // whether it left the sequential path.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } bp_update_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } resolver_state_t;

   // Sequential successor of a PC. The 32-bit sum wraps, so 0xFFFFFFFC -> 0.
   function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolver_if.sv
`default_nettype none
// ============================================================================
// Interface   : branch_resolver_if
// Description : Resolve-side inputs, redirect/flush outputs, predictor
//               training handshake and statistics counters of the branch
//               resolver. The master is the pipeline/predictor side, and the
//               slave is the resolver.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolver_if;
   logic        load_buffers;
   logic        res_valid;
   logic        res_is_ctrl;
   logic [31:0] res_pc;
   logic [31:0] res_pred_pc;
   logic [31:0] res_next_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        res_stall;
   logic        upd_valid;
   logic        upd_ready;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   modport master (
      output load_buffers, res_valid, res_is_ctrl, res_pc, res_pred_pc,
             res_next_pc, upd_ready,
      input  redirect_valid, redirect_pc, flush, res_stall, upd_valid,
             upd_pc, upd_target, upd_taken, branch_count, mispredict_count
   );

   modport slave (
      input  load_buffers, res_valid, res_is_ctrl, res_pc, res_pred_pc,
             res_next_pc, upd_ready,
      output redirect_valid, redirect_pc, flush, res_stall, upd_valid,
             upd_pc, upd_target, upd_taken, branch_count, mispredict_count
   );
endinterface
`default_nettype wire

// File: rtl/bp_update_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bp_update_fifo
// Description : Small synchronous FIFO of predictor training records.
//               Pointers carry one extra wrap bit to tell full from empty.
//               The head entry is presented combinationally, and it reads as
//               zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_update_fifo
   import rv32i_types::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  bp_update_t push_data,
   input  logic       pop,
   output bp_update_t pop_data,
   output logic       full,
   output logic       empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   bp_update_t  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_push_ok;
   logic        w_pop_ok;

   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;
   assign pop_data  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Storage is write-only on push and needs no reset; empty masks stale data.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Advance pointers on push and pop; reset discards every queued entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : Compares each resolved control-flow instruction's predicted
//               next PC with its actual next PC. On a mismatch it issues a
//               registered redirect and a flush lasting FLUSH_CYCLES cycles.
//               It queues predictor training records and keeps saturating
//               branch and mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver
   import rv32i_types::*;
#(
   parameter int UQ_DEPTH     = 4,
   parameter int FLUSH_CYCLES = 2
)
(
   input  logic              clk,
   input  logic              rst,
   branch_resolver_if.slave  bus
);

   localparam int            CW         = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [31:0]   SAT_MAX    = 32'hFFFF_FFFF;

   resolver_state_t r_state;
   logic [CW-1:0]   r_flush_cnt;
   logic            w_accept;
   logic            w_taken;
   logic            w_mispredict;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   bp_update_t      w_push_data;
   bp_update_t      w_head;

   // Only correct-path control instructions are considered. Anything that
   // arrives during FLUSH is wrong-path and is dropped.
   assign w_accept     = bus.load_buffers & bus.res_valid & bus.res_is_ctrl &
                         (r_state == RUN) & ~w_full;
   assign w_taken      = (bus.res_next_pc != seq_next_pc(bus.res_pc));
   assign w_mispredict = w_accept & (bus.res_pred_pc != bus.res_next_pc);
   assign w_pop        = ~w_empty & bus.upd_ready;
   assign w_push_data  = {bus.res_pc, bus.res_next_pc, w_taken};

   bp_update_fifo #(
      .DEPTH (UQ_DEPTH)
   ) u_update_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_accept),
      .push_data (w_push_data),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign bus.res_stall  = w_full;
   assign bus.upd_valid  = ~w_empty;
   assign bus.upd_pc     = w_head.pc;
   assign bus.upd_target = w_head.target;
   assign bus.upd_taken  = w_head.taken;

   // Redirect/flush FSM. The redirect cycle is the first flush cycle, and
   // the countdown runs whether or not the pipeline advances.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state            <= RUN;
         r_flush_cnt        <= '0;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
         bus.flush          <= 1'b0;
      end else begin
         bus.redirect_valid <= 1'b0;
         case (r_state)
            RUN: begin
               if (w_mispredict) begin
                  bus.redirect_valid <= 1'b1;
                  bus.redirect_pc    <= bus.res_next_pc;
                  bus.flush          <= 1'b1;
                  r_flush_cnt        <= FLUSH_LOAD;
                  r_state            <= FLUSH;
               end else begin
                  bus.flush <= 1'b0;
               end
            end
            FLUSH: begin
               if (r_flush_cnt == '0) begin
                  bus.flush <= 1'b0;
                  r_state   <= RUN;
               end else begin
                  bus.flush   <= 1'b1;
                  r_flush_cnt <= r_flush_cnt - CNT_ONE;
               end
            end
            default: begin
               bus.flush <= 1'b0;
               r_state   <= RUN;
            end
         endcase
      end
   end

   // Saturating statistics counters; they stick at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.branch_count     <= '0;
         bus.mispredict_count <= '0;
      end else begin
         if (w_accept && (bus.branch_count != SAT_MAX)) begin
            bus.branch_count <= bus.branch_count + 32'd1;
         end
         if (w_mispredict && (bus.mispredict_count != SAT_MAX)) begin
            bus.mispredict_count <= bus.mispredict_count + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer-side counterpart of the fetch branch predictor.
- Sits at the execute/writeback boundary and compares each resolved control-flow instruction's predicted next PC against its actual next PC.
- On a mismatch it issues a registered redirect and a pipeline flush.
- It queues training updates (pc, target, taken) in a small FIFO and drains them to the predictor's write port under a valid/ready handshake.
- It keeps saturating branch and mispredict counters.

Parameters:
- UQ_DEPTH, 4, update FIFO depth; power of two, ≥2.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect; ≥1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- load_buffers  input  1  pipeline advance enable; inputs are sampled only when high.
- res_valid  input  1  resolving instruction present.
- res_is_ctrl  input  1  instruction is br/jal/jalr.
- res_pc  input  32  instruction PC.
- res_pred_pc  input  32  next PC predicted at fetch.
- res_next_pc  input  32  actual next PC.
- redirect_valid  output  1  one-cycle pulse; fetch must load redirect_pc.
- redirect_pc  output  32  corrected fetch PC.
- flush  output  1  squash younger instructions.
- res_stall  output  1  update FIFO full; pipeline must hold.
- upd_valid  output  1  training entry available.
- upd_ready  input  1  predictor accepts entry.
- upd_pc  output  32  entry PC.
- upd_target  output  32  entry target; equals next PC.
- upd_taken  output  1  entry taken flag.
- branch_count  output  32  resolved control instructions.
- mispredict_count  output  32  mispredictions.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FIFO empty; FSM in RUN; counters 0.
- Resolve event: `accept = load_buffers & res_valid & res_is_ctrl & (state==RUN) & ~res_stall`.
- taken = (res_next_pc != res_pc + 32'd4). The sum wraps modulo 2^32, so pc 0xFFFFFFFC gives +4 = 0.
- mispredict = accept & (res_pred_pc != res_next_pc).
- Non-control and invalid instructions are ignored entirely: no enqueue, no count.
- FSM RUN:
  - On mispredict, the next cycle has redirect_valid=1, redirect_pc=res_next_pc and flush=1.
  - The FSM then moves to FLUSH with counter = FLUSH_CYCLES-1.
- FSM FLUSH:
  - flush=1 and redirect_valid=0; the counter decrements each cycle.
  - At 0 the FSM returns to RUN and flush=0 in the following cycle.
  - Total flush width is exactly FLUSH_CYCLES cycles, beginning with the redirect cycle.
  - All resolve inputs are ignored in FLUSH; they are wrong-path.
- redirect_valid never asserts on two consecutive cycles.
- Update FIFO:
  - Enqueue on accept, mispredicted or not.
  - Dequeue on upd_valid & upd_ready.
  - upd_* presents the head entry combinationally from storage; upd_valid = ~empty.
  - res_stall = full. When full and upd_ready=1 in the same cycle, res_stall still asserts, so there is no enqueue that cycle. Simultaneous bypass-when-full is not supported.
  - Simultaneous enqueue and dequeue when neither full nor empty: occupancy is unchanged.
  - Pointers are log2(UQ_DEPTH)+1 bits. full = MSBs differ and LSBs equal.
  - Enqueue while empty: upd_valid rises the next cycle, a latency of 1.
- Counters:
  - branch_count increments on accept; mispredict_count increments on mispredict.
  - Both saturate at 32'hFFFFFFFF.
- Reset mid-operation: an asynchronous clear from any state. The FIFO is discarded and pending updates are lost; this is acceptable because the predictor is only a hint.
- load_buffers=0: no state change except FIFO dequeue and FLUSH countdown, which proceed regardless.

Decomposition:
- Shared package rv32i_types gets typedef bp_update_t {logic [31:0] pc; logic [31:0] target; logic taken;}.
- rv32i_types also gets enum resolver_state_t {RUN, FLUSH}.
- The predictor's write side is then retargeted to consume bp_update_t.
- One sub-module is natural: bp_update_fifo, parameterised by depth and holding bp_update_t entries, with push/pop/full/empty.
- The resolve logic, FSM and counters stay in branch_resolver.

Test Plan:
- Correct not-taken: pc=0x100, pred=0x104, next=0x104 with load_buffers=1. Expect no redirect; FIFO entry {0x100,0x104,0}; branch_count=1; mispredict_count=0.
- Taken mispredict: pc=0x200, pred=0x204, next=0x180.
  - Next cycle: redirect_valid=1 with redirect_pc=0x180.
  - flush is high for exactly 2 cycles.
  - Entry {0x200,0x180,1}; mispredict_count=1.
- Wrong-path squash: a second mispredicting branch driven during FLUSH produces no redirect, no enqueue and no count change.
- FIFO full with upd_ready=0: 4 accepted correct branches, then res_stall=1 and a 5th branch is not counted. Raising upd_ready for 1 cycle pops pc of branch 1 and drops res_stall the next cycle.
- Wrap-around: pc=0xFFFFFFFC, next=0x00000000 is classified not-taken (upd_taken=0).
- Asynchronous reset asserted mid-FLUSH with 3 entries queued: all outputs 0 immediately; upd_valid=0; counters 0.
